// File: rtl/io1in_debounce.sv
// Single-bit pad input conditioner: synchronizer, debounce FSM, rise/fall strobes.
// Optional rising-edge counter built when IO1IN_EDGE_CNT_EN is defined.
module io1in_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          INIT            = 1'b0,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             real_rst,
  input  logic             pin_in,
  input  logic             cnt_clr,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_cnt
);

  localparam int unsigned    DbW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES);
  localparam logic [DbW-1:0] DbOne = DbW'(1);

  typedef enum logic [1:0] {
    StStableLo,
    StPendHi,
    StStableHi,
    StPendLo
  } state_e;

  localparam state_e StInit = INIT ? StStableHi : StStableLo;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  state_e                 state_q, state_d;
  logic [DbW-1:0]         db_cnt_q, db_cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
    s      = sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    unique case (state_q)
      StStableLo: begin
        if (s) begin
          state_d  = StPendHi;
          db_cnt_d = DbOne;
        end
      end
      StPendHi: begin
        if (!s) begin
          state_d  = StStableLo;
          db_cnt_d = '0;
        end else if (db_cnt_q == DbMax) begin
          state_d  = StStableHi;
          db_cnt_d = '0;
          level_d  = 1'b1;
          rise_d   = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DbOne;
        end
      end
      StStableHi: begin
        if (!s) begin
          state_d  = StPendLo;
          db_cnt_d = DbOne;
        end
      end
      StPendLo: begin
        if (s) begin
          state_d  = StStableHi;
          db_cnt_d = '0;
        end else if (db_cnt_q == DbMax) begin
          state_d  = StStableLo;
          db_cnt_d = '0;
          level_d  = 1'b0;
          fall_d   = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DbOne;
        end
      end
      default: begin
        state_d  = StInit;
        db_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge real_rst) begin
    if (real_rst) begin
      sync_q   <= {SYNC_STAGES{INIT}};
      state_q  <= StInit;
      db_cnt_q <= '0;
      level_q  <= INIT;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef IO1IN_EDGE_CNT_EN
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;

  // Counts off rise_d so edge_cnt updates in the same cycle the strobe appears.
  always_comb begin
    edge_cnt_d = edge_cnt_q + CNT_W'(rise_d);
    if (cnt_clr) begin
      edge_cnt_d = CNT_W'(rise_d);
    end
  end

  always_ff @(posedge clk or posedge real_rst) begin
    if (real_rst) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign edge_cnt       = '0;
`endif

endmodule

// File: tb/tb_io1in_debounce.sv
// Scoreboard bench for io1in_debounce at default parameters; expected strobes are
// queued at stimulus time and popped by a monitor whenever rise or fall is seen.
module tb_io1in_debounce;

  localparam int unsigned Latency = 19;  // drive after edge N -> strobe visible after edge N+19

`ifdef IO1IN_EDGE_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  typedef struct packed {
    logic        is_rise;
    int unsigned cyc;
    logic [7:0]  ecnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       real_rst = 1'b1;
  logic       pin_in = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       level, rise, fall;
  logic [7:0] edge_cnt;

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  model_ecnt = 8'd0;
  exp_t        q[$];
  exp_t        mon_e;

  io1in_debounce dut (
    .clk      (clk),
    .real_rst (real_rst),
    .pin_in   (pin_in),
    .cnt_clr  (cnt_clr),
    .level    (level),
    .rise     (rise),
    .fall     (fall),
    .edge_cnt (edge_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit is_rise);
    exp_t e;
    if (is_rise && CntEn) model_ecnt = model_ecnt + 8'd1;
    e.is_rise = is_rise;
    e.cyc     = cyc + Latency;
    e.ecnt    = model_ecnt;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rise || fall) begin
      check("rise_fall_exclusive", {31'd0, rise & fall}, 32'd0);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got rise=%0b fall=%0b at cyc %0d, want none",
                 rise, fall, cyc);
      end else begin
        mon_e = q.pop_front();
        check("strobe_kind", {31'd0, rise}, {31'd0, mon_e.is_rise});
        check("strobe_cycle", cyc, mon_e.cyc);
        check("strobe_level", {31'd0, level}, {31'd0, mon_e.is_rise});
        check("strobe_edge_cnt", {24'd0, edge_cnt}, {24'd0, mon_e.ecnt});
      end
    end
  end

  initial begin
    // Reset held while pin toggles
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 pin_in = ~pin_in;
      @(negedge clk);
      check("rst_level", {31'd0, level}, 32'd0);
      check("rst_rise", {31'd0, rise}, 32'd0);
      check("rst_fall", {31'd0, fall}, 32'd0);
      check("rst_edge_cnt", {24'd0, edge_cnt}, 32'd0);
    end
    tick(1);
    real_rst = 1'b0;
    pin_in   = 1'b0;
    tick(5);

    // Clean rise then fall
    pin_in = 1'b1;
    push_exp(1'b1);
    tick(25);
    check("clean_level_hi", {31'd0, level}, 32'd1);
    pin_in = 1'b0;
    push_exp(1'b0);
    tick(25);
    check("clean_level_lo", {31'd0, level}, 32'd0);

    // Glitch: 15 high, low, bounce 3/2, then steady high
    pin_in = 1'b1;
    tick(15);
    pin_in = 1'b0;
    tick(4);
    pin_in = 1'b1;
    tick(3);
    pin_in = 1'b0;
    tick(2);
    pin_in = 1'b1;
    push_exp(1'b1);
    tick(25);
    pin_in = 1'b0;
    push_exp(1'b0);
    tick(25);

    // Reset 10 cycles into PEND_HI
    pin_in = 1'b1;
    tick(13);
    real_rst   = 1'b1;
    model_ecnt = 8'd0;
    @(negedge clk);
    check("midrst_level", {31'd0, level}, 32'd0);
    check("midrst_rise", {31'd0, rise}, 32'd0);
    check("midrst_edge_cnt", {24'd0, edge_cnt}, 32'd0);
    tick(3);
    real_rst = 1'b0;
    push_exp(1'b1);
    tick(25);
    pin_in = 1'b0;
    push_exp(1'b0);
    tick(25);

    // 256 accepted rises: counter wraps
    for (int i = 0; i < 256; i++) begin
      pin_in = 1'b1;
      push_exp(1'b1);
      tick(20);
      pin_in = 1'b0;
      push_exp(1'b0);
      tick(20);
    end

    // cnt_clr alone
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr    = 1'b0;
    model_ecnt = 8'd0;
    @(negedge clk);
    check("clr_alone_edge_cnt", {24'd0, edge_cnt}, 32'd0);
    tick(1);
    pin_in = 1'b1;
    push_exp(1'b1);
    tick(20);
    pin_in = 1'b0;
    push_exp(1'b0);
    tick(20);

    // cnt_clr coincident with rise generation
    model_ecnt = 8'd0;
    pin_in = 1'b1;
    push_exp(1'b1);
    tick(Latency - 1);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    tick(21);
    pin_in = 1'b0;
    push_exp(1'b0);
    tick(40);

    check("scoreboard_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
